// File: rtl/wsg_write_arbiter.sv
// wsg_write_arbiter
// Merges register writes from the main CPU (A) and the sound CPU (B) into
// the 64-byte WSG register window. Each requester has its own FIFO; the
// two streams are merged with round-robin arbitration and issued as
// single-cycle write strobes separated by GAP idle cycles.
//
// Optional build macro WSG_ARB_MUTE_EN: builds the mute sequencer, which
// writes 8'h00 to the volume register of channels 0..7 (offset {ch,3'b011}).
// Without it, mute_req is ignored and mute_busy is tied low.
//
// Ports:
//   pxclk               clock, all logic on rising edge
//   RESET               synchronous active-high reset
//   a_wr/a_addr/a_data  main-CPU write request (offset, data)
//   a_full              main-CPU FIFO full
//   b_wr/b_addr/b_data  sound-CPU write request
//   b_full              sound-CPU FIFO full
//   mute_req            pulse requesting the mute sequence
//   mute_busy           mute sequence accepted and not yet finished
//   ovf                 sticky overflow flags, bit0 = A, bit1 = B
//   SA/SD/cpu_wr        WSG write port; SA/SD hold while cpu_wr is low
module wsg_write_arbiter #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned GAP        = 1
) (
    input  logic        pxclk,
    input  logic        RESET,
    input  logic        a_wr,
    input  logic [5:0]  a_addr,
    input  logic [7:0]  a_data,
    output logic        a_full,
    input  logic        b_wr,
    input  logic [5:0]  b_addr,
    input  logic [7:0]  b_data,
    output logic        b_full,
    input  logic        mute_req,
    output logic        mute_busy,
    output logic [1:0]  ovf,
    output logic [15:0] SA,
    output logic [7:0]  SD,
    output logic        cpu_wr
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned PW       = DEPTH_LOG2;
    localparam int unsigned CW       = DEPTH_LOG2 + 1;
    localparam int unsigned EW       = 14;
    localparam logic [3:0]  GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam bit          GAP_EN   = (GAP != 0);

`ifdef WSG_ARB_MUTE_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_MUTE_ISSUE,
        ST_MUTE_GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } state_t;
`endif

    // ---------------- per-requester FIFOs (index 0 = A, 1 = B) ----------------
    logic [EW-1:0] mem   [2][DEPTH];
    logic [PW-1:0] wptr  [2];
    logic [PW-1:0] rptr  [2];
    logic [CW-1:0] cnt   [2];
    logic [EW-1:0] wdata [2];
    logic [EW-1:0] head  [2];
    logic [1:0]    wr;
    logic [1:0]    full;
    logic [1:0]    empty;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    ovf_q;

    assign wr       = {b_wr, a_wr};
    assign wdata[0] = {a_addr, a_data};
    assign wdata[1] = {b_addr, b_data};

    // Full is decoded from the registered count, so a same-cycle pop never
    // makes room for a push.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            full[r]  = (cnt[r] == CW'(DEPTH));
            empty[r] = (cnt[r] == '0);
            push[r]  = wr[r] & ~full[r];
            head[r]  = mem[r][rptr[r]];
        end
    end

    // FIFO pointers, counts and sticky overflow flags
    always_ff @(posedge pxclk) begin
        if (RESET) begin
            for (int r = 0; r < 2; r++) begin
                wptr[r] <= '0;
                rptr[r] <= '0;
                cnt[r]  <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r]) wptr[r] <= wptr[r] + PW'(1);
                if (pop[r])  rptr[r] <= rptr[r] + PW'(1);
                cnt[r] <= cnt[r] + CW'(push[r]) - CW'(pop[r]);
                if (wr[r] && full[r]) ovf_q[r] <= 1'b1;
            end
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge pxclk) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) mem[r][wptr[r]] <= wdata[r];
        end
    end

    // ---------------- issue FSM ----------------
    state_t     state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic       rr_q, rr_d;          // 1 = B was granted last
    logic       cpu_wr_q, cpu_wr_d;
    logic [5:0] off_q, off_d;
    logic [7:0] sd_q, sd_d;
    logic       sel;                 // pick the next source this cycle

`ifdef WSG_ARB_MUTE_EN
    logic [2:0] ch_q, ch_d;
    logic       pend_q, pend_d;
    logic       busy_q, busy_d;
    logic       in_mute;
    logic       mute_nxt;            // advance to the next mute channel

    assign in_mute = (state_q == ST_MUTE_ISSUE) || (state_q == ST_MUTE_GAP);
`endif

    // Next state and next registered outputs
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        rr_d     = rr_q;
        cpu_wr_d = 1'b0;
        off_d    = off_q;
        sd_d     = sd_q;
        pop      = 2'b00;
        sel      = 1'b0;
`ifdef WSG_ARB_MUTE_EN
        ch_d     = ch_q;
        mute_nxt = 1'b0;
        // Requests while pending or sequencing are merged.
        pend_d   = pend_q | (mute_req & ~in_mute);
`endif

        case (state_q)
            ST_IDLE: sel = 1'b1;
            ST_ISSUE: begin
                if (GAP_EN) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else begin
                    sel = 1'b1;
                end
            end
            ST_GAP: begin
                // The last gap cycle already selects, keeping GAP+1 spacing.
                if (gap_q == GAP_LAST) sel = 1'b1;
                else                   gap_d = gap_q + 4'd1;
            end
`ifdef WSG_ARB_MUTE_EN
            ST_MUTE_ISSUE: begin
                if (GAP_EN) begin
                    state_d = ST_MUTE_GAP;
                    gap_d   = '0;
                end else if (ch_q == 3'd7) begin
                    sel = 1'b1;
                end else begin
                    mute_nxt = 1'b1;
                end
            end
            ST_MUTE_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (ch_q == 3'd7) sel = 1'b1;
                    else              mute_nxt = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef WSG_ARB_MUTE_EN
        if (mute_nxt) begin
            ch_d     = ch_q + 3'd1;
            state_d  = ST_MUTE_ISSUE;
            cpu_wr_d = 1'b1;
            off_d    = {ch_d, 3'b011};
            sd_d     = 8'h00;
        end
`endif

        // Source priority: pending mute, then sole non-empty FIFO, then the
        // FIFO not granted last.
        if (sel) begin
            state_d = ST_IDLE;
`ifdef WSG_ARB_MUTE_EN
            if (pend_q) begin
                pend_d   = 1'b0;
                ch_d     = 3'd0;
                state_d  = ST_MUTE_ISSUE;
                cpu_wr_d = 1'b1;
                off_d    = 6'b000011;
                sd_d     = 8'h00;
            end else
`endif
            if (!empty[0] && (empty[1] || rr_q)) begin
                pop[0]   = 1'b1;
                rr_d     = 1'b0;
                state_d  = ST_ISSUE;
                cpu_wr_d = 1'b1;
                off_d    = head[0][13:8];
                sd_d     = head[0][7:0];
            end else if (!empty[1]) begin
                pop[1]   = 1'b1;
                rr_d     = 1'b1;
                state_d  = ST_ISSUE;
                cpu_wr_d = 1'b1;
                off_d    = head[1][13:8];
                sd_d     = head[1][7:0];
            end
        end

`ifdef WSG_ARB_MUTE_EN
        busy_d = pend_q | (state_d == ST_MUTE_ISSUE) | (state_d == ST_MUTE_GAP);
`endif
    end

    // FSM state and write-port registers
    always_ff @(posedge pxclk) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            rr_q     <= 1'b1;
            cpu_wr_q <= 1'b0;
            off_q    <= '0;
            sd_q     <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            rr_q     <= rr_d;
            cpu_wr_q <= cpu_wr_d;
            off_q    <= off_d;
            sd_q     <= sd_d;
        end
    end

`ifdef WSG_ARB_MUTE_EN
    // Mute sequencer registers
    always_ff @(posedge pxclk) begin
        if (RESET) begin
            ch_q   <= '0;
            pend_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
        end
    end

    assign mute_busy = busy_q;
`else
    logic unused_mute;
    assign unused_mute = mute_req;
    assign mute_busy   = 1'b0;
`endif

    assign a_full = full[0];
    assign b_full = full[1];
    assign ovf    = ovf_q;
    assign cpu_wr = cpu_wr_q;
    assign SA     = {10'h000, off_q};
    assign SD     = sd_q;

endmodule
